// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control.
// Register width, FSM encodings, zero register.
package mips_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection for the ID stage.
// Flags load-use and branch-operand hazards.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int W = REG_ADDR_W
) (
  input  logic [W-1:0] i_Rs,
  input  logic [W-1:0] i_Rt,
  input  logic         i_UsesRt,
  input  logic         i_Branch,
  input  logic         i_IDEX_MemRead,
  input  logic         i_IDEX_RegWrite,
  input  logic [W-1:0] i_IDEX_WriteReg,
  input  logic         i_EXMEM_MemRead,
  input  logic [W-1:0] i_EXMEM_WriteReg,
  output logic         o_Stall
);

  logic w_ex_match;
  logic w_mem_match;
  logic w_load_use;
  logic w_br_alu;
  logic w_br_load;

  // Source-operand match against EX and MEM destinations; $0 never matches.
  always_comb begin
    w_ex_match  = (i_IDEX_WriteReg != W'(ZERO_REG)) &&
                  ((i_IDEX_WriteReg == i_Rs) ||
                   (i_UsesRt && (i_IDEX_WriteReg == i_Rt)));
    w_mem_match = (i_EXMEM_WriteReg != W'(ZERO_REG)) &&
                  ((i_EXMEM_WriteReg == i_Rs) ||
                   (i_UsesRt && (i_EXMEM_WriteReg == i_Rt)));
    w_load_use  = i_IDEX_MemRead && w_ex_match;
    w_br_alu    = i_Branch && i_IDEX_RegWrite &&
                  !i_IDEX_MemRead && w_ex_match;
    w_br_load   = i_Branch && i_EXMEM_MemRead && w_mem_match;
    o_Stall     = w_load_use || w_br_alu || w_br_load;
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/enable/flush control with halt drain,
// debug freeze and a saturating stall-cycle counter.
module hazard_stall_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W   = mips_pkg::REG_ADDR_W,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [REG_ADDR_W-1:0] i_IFID_Rs,
  input  logic [REG_ADDR_W-1:0] i_IFID_Rt,
  input  logic                  i_IFID_UsesRt,
  input  logic                  i_IFID_Branch,
  input  logic                  i_IFID_Halt,
  input  logic                  i_BranchTaken,
  input  logic                  i_IDEX_MemRead,
  input  logic                  i_IDEX_RegWrite,
  input  logic [REG_ADDR_W-1:0] i_IDEX_WriteReg,
  input  logic                  i_EXMEM_MemRead,
  input  logic [REG_ADDR_W-1:0] i_EXMEM_WriteReg,
  input  logic                  i_DebugMode,
  input  logic                  i_Step,
  output logic                  o_StallControl,
  output logic                  o_PCWrite,
  output logic                  o_IFIDWrite,
  output logic                  o_IFIDFlush,
  output logic                  o_PipeEnable,
  output logic                  o_Halted,
  output logic [1:0]            o_State,
  output logic [CNT_W-1:0]      o_StallCount
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [DW-1:0]   r_drain;
  logic [DW-1:0]   w_drain_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic            w_stall;
  logic            w_freeze;

  hazard_detect #(.W(REG_ADDR_W)) u_hazard_detect (
    .i_Rs             (i_IFID_Rs),
    .i_Rt             (i_IFID_Rt),
    .i_UsesRt         (i_IFID_UsesRt),
    .i_Branch         (i_IFID_Branch),
    .i_IDEX_MemRead   (i_IDEX_MemRead),
    .i_IDEX_RegWrite  (i_IDEX_RegWrite),
    .i_IDEX_WriteReg  (i_IDEX_WriteReg),
    .i_EXMEM_MemRead  (i_EXMEM_MemRead),
    .i_EXMEM_WriteReg (i_EXMEM_WriteReg),
    .o_Stall          (w_stall)
  );

  assign w_freeze = i_DebugMode && !i_Step;

  // Next-state and control outputs; a step cycle behaves as RUN.
  always_comb begin
    w_state_nxt    = r_state;
    w_drain_nxt    = r_drain;
    o_StallControl = 1'b0;
    o_PCWrite      = 1'b0;
    o_IFIDWrite    = 1'b0;
    o_IFIDFlush    = 1'b0;
    o_PipeEnable   = 1'b0;
    unique case (r_state)
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      ST_DRAIN: begin
        o_IFIDWrite  = 1'b1;
        o_IFIDFlush  = 1'b1;
        o_PipeEnable = 1'b1;
        if (r_drain == DW'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = ST_HALTED;
          w_drain_nxt = '0;
        end else begin
          w_drain_nxt = r_drain + DW'(1);
        end
      end
      ST_RUN, ST_FROZEN: begin
        if (w_freeze) begin
          w_state_nxt = ST_FROZEN;
        end else begin
          o_PipeEnable = 1'b1;
          if (w_stall) begin
            o_StallControl = 1'b1;
          end else begin
            o_PCWrite   = 1'b1;
            o_IFIDWrite = 1'b1;
            o_IFIDFlush = i_BranchTaken;
          end
          if (i_IFID_Halt && !w_stall)
            w_state_nxt = ST_DRAIN;
          else if (i_DebugMode)
            w_state_nxt = ST_FROZEN;
          else
            w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State and drain-counter registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_RUN;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // Saturating count of stall cycles in which the pipeline advanced.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall_cnt <= '0;
    end else if (o_StallControl && o_PipeEnable &&
                 (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_Halted     = (r_state == ST_HALTED);
  assign o_State      = r_state;
  assign o_StallCount = r_stall_cnt;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Generates the stall, enable and flush controls for the 5-stage MIPS pipeline.
- o_StallControl drives the control-zeroing mux between decode and ID/EX. The unit also drives the PC and IF/ID write enables.
- Owns the halt-drain sequence and the debug single-step freeze.
- Keeps a saturating stall-cycle counter for the debug unit.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- DRAIN_CYCLES, 4, cycles from halt acceptance to HALTED.
- CNT_W, 32, stall counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_IFID_Rs  in  REG_ADDR_W  rs of the instruction in ID.
- i_IFID_Rt  in  REG_ADDR_W  rt of the instruction in ID.
- i_IFID_UsesRt  in  1  the ID instruction reads rt.
- i_IFID_Branch  in  1  the ID instruction is beq/bne, resolved in ID.
- i_IFID_Halt  in  1  the ID instruction is halt.
- i_BranchTaken  in  1  ID branch/jump redirect this cycle.
- i_IDEX_MemRead  in  1  the EX instruction is a load.
- i_IDEX_RegWrite  in  1  the EX instruction writes a register.
- i_IDEX_WriteReg  in  REG_ADDR_W  EX destination register.
- i_EXMEM_MemRead  in  1  the MEM instruction is a load.
- i_EXMEM_WriteReg  in  REG_ADDR_W  MEM destination register.
- i_DebugMode  in  1  pipeline runs only on step pulses.
- i_Step  in  1  single-cycle advance pulse.
- o_StallControl  out  1  zeroes the ID control word.
- o_PCWrite  out  1  PC write enable.
- o_IFIDWrite  out  1  IF/ID write enable.
- o_IFIDFlush  out  1  clears IF/ID to a nop.
- o_PipeEnable  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- o_Halted  out  1  the pipeline has stopped.
- o_State  out  2  current FSM state.
- o_StallCount  out  CNT_W  count of stall cycles.

Behaviour:
- Reset (async assert, synchronous release):
  - FSM=RUN, drain counter=0, o_StallCount=0, o_Halted=0.
  - Combinational outputs follow the RUN rules.
- Match rule: a source matches when dest==rs, or when UsesRt && dest==rt. dest==0 never matches.
- Hazards, evaluated combinationally in the same cycle:
  - Load-use: i_IDEX_MemRead and match -> stall.
  - Branch after ALU: i_IFID_Branch, i_IDEX_RegWrite, not MemRead, and match -> stall.
  - Branch after load: i_IFID_Branch, i_EXMEM_MemRead and EXMEM match -> stall. The load two ahead gives 2 stalls naturally: one via IDEX, one via EXMEM.
- Stall cycle:
  - o_StallControl=1, o_PCWrite=0, o_IFIDWrite=0, o_IFIDFlush=0, o_PipeEnable=1.
  - On a stall cycle, i_BranchTaken is ignored.
- No stall: o_PCWrite=1, o_IFIDWrite=1, o_IFIDFlush=i_BranchTaken.
- FSM states: RUN=0, DRAIN=1, HALTED=2, FROZEN=3.
  - RUN -> DRAIN when i_IFID_Halt and no stall. In that cycle, halt passes to ID/EX normally.
  - DRAIN: PCWrite=0, IFIDWrite=1, IFIDFlush=1, StallControl=0. Counter counts 1..DRAIN_CYCLES, then -> HALTED.
  - HALTED: PCWrite=0, IFIDWrite=0, PipeEnable=0, o_Halted=1. Exit only via reset.
  - FROZEN: entered from RUN when i_DebugMode=1 and i_Step=0. All enables are 0, StallControl=0, counter frozen.
  - A cycle with i_Step=1 behaves exactly as RUN for one cycle, including hazards and halt.
  - FROZEN -> RUN when i_DebugMode=0.
  - DebugMode has no effect in DRAIN or HALTED.
- Priority: reset > HALTED > DRAIN > FROZEN > hazard stall > flush.
- o_StallCount: +1 on every cycle with o_StallControl=1 and the pipeline advancing. Saturates at all-ones.
- Reset mid-DRAIN returns to RUN, counter=0.

Decomposition:
- Shared package mips_pkg:
  - REG_ADDR_W.
  - FSM state encodings ST_RUN, ST_DRAIN, ST_HALTED, ST_FROZEN.
  - Zero-register constant.
- Sub-module hazard_detect: purely combinational match/stall logic.
- The FSM, drain counter and stall counter stay in the top module.

Test Plan:
- lw $2 in EX, ID add rs=2 -> exactly 1 cycle: StallControl=1, PCWrite=0, IFIDWrite=0. Then PCWrite=1. StallCount=1.
- lw $3 in EX, ID beq rt=3 -> 2 consecutive stall cycles (IDEX, then EXMEM). StallCount=2.
- IDEX RegWrite dest=0, ID rs=0 -> no stall. Same with dest=5 but UsesRt=0, rt=5 -> no stall.
- No hazard, i_BranchTaken=1 -> IFIDFlush=1, PCWrite=1.
- Load-use coincident with i_BranchTaken -> stall only, IFIDFlush=0.
- Halt in ID, DRAIN_CYCLES=4 -> DRAIN for 4 cycles with IFIDFlush=1, then o_Halted=1, o_State=2, PipeEnable=0. Holds there. Reset_n low on drain cycle 2 -> o_State=0, o_Halted=0 immediately.
- DebugMode=1 -> all enables 0, StallCount frozen. One i_Step pulse with load-use present -> one stall cycle counted. Then frozen again.
